// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet stream loader: controller state
// encoding and default parameter values.
package maxnet_pkg;

  localparam int WIDTH_DEF      = 5;
  localparam int MAX_CYCLES_DEF = 64;
  localparam int DONE_GUARD_DEF = 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/maxnet_stream_loader_if.sv
// Handshake bundle between the loader and its surroundings.
//   in_*   : serial sample stream into the loader (valid/ready)
//   X1..X4 : parallel operands to the Maxnet datapath
//   start/done/maximum_number : controller and datapath control
//   res_*  : result stream out of the loader (valid/ready)
// slave  = the loader, master = the environment driving it.
interface maxnet_stream_loader_if
  import maxnet_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X1, X2, X3, X4;
  logic             start;
  logic             done;
  logic [31:0]      maximum_number;
  logic [31:0]      res_data;
  logic             res_timeout;
  logic             res_valid;
  logic             res_ready;

  modport slave (
    input  in_data, in_valid, done, maximum_number, res_ready,
    output in_ready, X1, X2, X3, X4, start, res_data, res_timeout, res_valid
  );

  modport master (
    output in_data, in_valid, done, maximum_number, res_ready,
    input  in_ready, X1, X2, X3, X4, start, res_data, res_timeout, res_valid
  );
endinterface

// File: rtl/maxnet_sample_buffer.sv
// Four-slot operand buffer filled in order 0..3.
//   wr_en/wr_data : write the next slot; index wraps after slot 3
//   slots         : current operand values (slot 0 = X1)
//   full          : combinational pulse on the write that fills slot 3
module maxnet_sample_buffer
  import maxnet_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [3:0][WIDTH-1:0] slots,
  output logic                  full
);
  logic [1:0] idx;

  assign full = wr_en && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= '0;
      slots <= '0;
    end else if (wr_en) begin
      idx <= idx + 2'd1;  // natural 2-bit wrap returns to slot 0
      for (int s = 0; s < 4; s++)
        if (idx == 2'(s)) slots[s] <= wr_data;
    end
  end
endmodule

// File: rtl/maxnet_stream_loader.sv
// Front end of the Maxnet pair: collects four serial samples into X1..X4,
// pulses start, waits for done (or the watchdog), captures maximum_number
// and offers it on the result handshake.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of maxnet_stream_loader_if
module maxnet_stream_loader
  import maxnet_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int DONE_GUARD = DONE_GUARD_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  maxnet_stream_loader_if.slave bus
);
  localparam int CW = $clog2(MAX_CYCLES + 1);

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [3:0][WIDTH-1:0]   slots;
  logic                    full;
  logic                    accept;
  logic                    done_q;
  logic                    wdog;
  logic [31:0]             res_data_q;
  logic                    res_to_q;

  assign accept = (state == LOAD) && bus.in_valid;
  // Stale datapath state can show done early in a job; mask the first cycles.
  assign done_q = bus.done && (cnt >= CW'(DONE_GUARD));
  assign wdog   = (cnt == CW'(MAX_CYCLES - 1));

  maxnet_sample_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (bus.in_data),
    .slots   (slots),
    .full    (full)
  );

  assign bus.X1          = slots[0];
  assign bus.X2          = slots[1];
  assign bus.X3          = slots[2];
  assign bus.X4          = slots[3];
  assign bus.res_data    = res_data_q;
  assign bus.res_timeout = res_to_q;

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.start     = 1'b0;
    bus.res_valid = 1'b0;
    case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (full) state_nxt = START;
      end
      START: begin
        bus.start = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (done_q || wdog) state_nxt = RESULT;
      end
      RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      cnt        <= '0;
      res_data_q <= '0;
      res_to_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == START) cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      // done takes priority over a same-cycle watchdog expiry
      if (state == RUN) begin
        if (done_q) begin
          res_data_q <= bus.maximum_number;
          res_to_q   <= 1'b0;
        end else if (wdog) begin
          res_data_q <= '0;
          res_to_q   <= 1'b1;
        end
      end
    end
  end
endmodule
